free_mode_poly: RTL and testbench

- Polyphonic successor to the single-note free-play path.
- Consumes the byte stream from the PS/2 decoder: make codes, F0 break prefix and E0 extended prefix.
- Tracks held keys from a parametrised keymap and allocates them to NUM_VOICES voice slots.
- Maintains octave selection for the downstream sound generator.
- Sits between the PS/2 decoder (data/out_en) and a multi-voice sound_top.

---
 rtl/free_mode_poly.sv | 203 ++++++++++++++++++++
 tb/tb_free_mode_poly.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_mode_poly.sv
`default_nettype none
// ============================================================================
//  Module   : free_mode_poly
//  Purpose  : Polyphonic PS/2 key-to-voice allocator with octave control.
//             Optional macro VOICE_STEAL_EN: steal the oldest voice when full.
//  Revision : 1.0  initial release
// ============================================================================
module free_mode_poly #(
  parameter int                    NUM_KEYS   = 8,
  parameter int                    NUM_VOICES = 4,
  parameter logic [NUM_KEYS*8-1:0] KEYMAP     = 64'h423B33342B231B1C,
  parameter logic [7:0]            OCT_DN     = 8'h1A,
  parameter logic [7:0]            OCT_UP     = 8'h22,
  parameter logic [1:0]            OCT_RST    = 2'd1
) (
  input  logic                                     sys_clk,
  input  logic                                     rst,
  input  logic [7:0]                               key_code,
  input  logic                                     key_valid,
  output logic [NUM_VOICES-1:0]                    voice_active,
  output logic [NUM_VOICES*$clog2(NUM_KEYS)-1:0]   voice_key,
  output logic [NUM_KEYS-1:0]                      key_held,
  output logic [1:0]                               octave,
  output logic                                     drop_pulse
);

  localparam int KEY_IDX_W = $clog2(NUM_KEYS);
  localparam int AGE_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [AGE_W-1:0] c_age_max  = AGE_W'(NUM_VOICES - 1);
  localparam logic [7:0]       c_code_brk = 8'hF0;
  localparam logic [7:0]       c_code_ext = 8'hE0;

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_brk     = 2'd1;
  localparam logic [1:0] c_st_ext     = 2'd2;
  localparam logic [1:0] c_st_ext_brk = 2'd3;

  logic [1:0]                      r_state;
  logic [NUM_VOICES-1:0]           r_active;
  logic [NUM_VOICES*KEY_IDX_W-1:0] r_vkey;
  logic [AGE_W-1:0]                r_age [NUM_VOICES];
  logic [NUM_KEYS-1:0]             r_held;
  logic [1:0]                      r_oct;
  logic                            r_drop;

  logic [1:0]                      w_state;
  logic [NUM_VOICES-1:0]           w_active;
  logic [NUM_VOICES*KEY_IDX_W-1:0] w_vkey;
  logic [AGE_W-1:0]                w_age [NUM_VOICES];
  logic [NUM_KEYS-1:0]             w_held;
  logic [1:0]                      w_oct;
  logic                            w_drop;

  logic                 w_hit;
  logic [KEY_IDX_W-1:0] w_idx;
  logic                 w_free_found;
  logic [AGE_W-1:0]     w_free_slot;
  logic                 w_alloc;
  logic [AGE_W-1:0]     w_slot;

  // Keymap lookup; scanning downward leaves the lowest matching index.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_code == KEYMAP[8*i +: 8]) begin
        w_hit = 1'b1;
        w_idx = KEY_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!r_active[v]) begin
        w_free_found = 1'b1;
        w_free_slot  = AGE_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] w_victim;
  logic [AGE_W-1:0] w_victim_age;

  // Oldest voice wins; strict compare keeps the lowest index on ties.
  always_comb begin
    w_victim     = '0;
    w_victim_age = r_age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (r_age[v] > w_victim_age) begin
        w_victim     = AGE_W'(v);
        w_victim_age = r_age[v];
      end
    end
  end
`endif

  always_comb begin
    w_state  = r_state;
    w_active = r_active;
    w_vkey   = r_vkey;
    w_age    = r_age;
    w_held   = r_held;
    w_oct    = r_oct;
    w_drop   = 1'b0;
    w_alloc  = 1'b0;
    w_slot   = '0;

    if (key_valid) begin
      case (r_state)
        c_st_idle: begin
          if (key_code == c_code_brk) begin
            w_state = c_st_brk;
          end else if (key_code == c_code_ext) begin
            w_state = c_st_ext;
          end else begin
            if (key_code == OCT_UP) begin
              if (r_oct != 2'd3) w_oct = r_oct + 2'd1;
            end else if (key_code == OCT_DN) begin
              if (r_oct != 2'd0) w_oct = r_oct - 2'd1;
            end
            // A held key is a typematic repeat and leaves everything alone.
            if (w_hit && !r_held[w_idx]) begin
              w_held[w_idx] = 1'b1;
              if (w_free_found) begin
                w_alloc = 1'b1;
                w_slot  = w_free_slot;
              end else begin
                w_drop = 1'b1;
`ifdef VOICE_STEAL_EN
                w_alloc = 1'b1;
                w_slot  = w_victim;
`endif
              end
            end
          end
        end
        c_st_brk: begin
          w_state = c_st_idle;
          if (w_hit && r_held[w_idx]) begin
            w_held[w_idx] = 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (r_active[v] && r_vkey[v*KEY_IDX_W +: KEY_IDX_W] == w_idx) begin
                w_active[v] = 1'b0;
                w_age[v]    = '0;
              end
            end
          end
        end
        c_st_ext: begin
          w_state = (key_code == c_code_brk) ? c_st_ext_brk : c_st_idle;
        end
        default: begin
          w_state = c_st_idle;
        end
      endcase
    end

    if (w_alloc) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (AGE_W'(v) == w_slot) begin
          w_active[v]                       = 1'b1;
          w_vkey[v*KEY_IDX_W +: KEY_IDX_W]  = w_idx;
          w_age[v]                          = '0;
        end else if (r_active[v] && r_age[v] != c_age_max) begin
          w_age[v] = r_age[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_active <= '0;
      r_vkey   <= '0;
      r_held   <= '0;
      r_oct    <= OCT_RST;
      r_drop   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
    end else begin
      r_state  <= w_state;
      r_active <= w_active;
      r_vkey   <= w_vkey;
      r_held   <= w_held;
      r_oct    <= w_oct;
      r_drop   <= w_drop;
      for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= w_age[v];
    end
  end

  assign voice_active = r_active;
  assign voice_key    = r_vkey;
  assign key_held     = r_held;
  assign octave       = r_oct;
  assign drop_pulse   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_free_mode_poly.sv
`default_nettype none
// ============================================================================
//  Module   : tb_free_mode_poly
//  Purpose  : Scoreboard bench for free_mode_poly against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_free_mode_poly;

  localparam int NK = 8;
  localparam int NV = 4;
  localparam int KW = 3;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        key_code = 8'h00;
  logic              key_valid = 1'b0;
  logic [NV-1:0]     voice_active;
  logic [NV*KW-1:0]  voice_key;
  logic [NK-1:0]     key_held;
  logic [1:0]        octave;
  logic              drop_pulse;

  always #5 sys_clk = ~sys_clk;

  free_mode_poly dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .key_held     (key_held),
    .octave       (octave),
    .drop_pulse   (drop_pulse)
  );

  typedef struct packed {
    logic [NV-1:0]    act;
    logic [NV*KW-1:0] vkey;
    logic [NK-1:0]    held;
    logic [1:0]       oct;
    logic             drop;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // A S D F G H J K
  logic [7:0] keymap [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};

  // Model state: which keys are down, what each voice plays and how old it is.
  bit m_act [NV];
  int m_key [NV];
  int m_age [NV];
  bit m_held[NK];
  int m_oct;
  bit m_drop;
  bit m_after_f0, m_after_e0, m_after_e0f0;

  function automatic int lookup(input logic [7:0] b);
    for (int i = 0; i < NK; i++) if (keymap[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_key[v] = 0; m_age[v] = 0; end
    for (int k = 0; k < NK; k++) m_held[k] = 0;
    m_oct = 1; m_drop = 0;
    m_after_f0 = 0; m_after_e0 = 0; m_after_e0f0 = 0;
  endtask

  task automatic model_press(input logic [7:0] b);
    int k, slot;
    if (b == 8'h22) m_oct = (m_oct < 3) ? m_oct + 1 : 3;
    else if (b == 8'h1A) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
    k = lookup(b);
    if (k < 0 || m_held[k]) return;
    m_held[k] = 1;
    slot = -1;
    for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) slot = v;
    if (slot < 0) begin
      m_drop = 1;
`ifdef VOICE_STEAL_EN
      slot = 0;
      for (int v = 1; v < NV; v++) if (m_age[v] > m_age[slot]) slot = v;
`endif
    end
    if (slot < 0) return;
    for (int v = 0; v < NV; v++)
      if (v != slot && m_act[v]) m_age[v] = (m_age[v] + 1 > NV - 1) ? NV - 1 : m_age[v] + 1;
    m_act[slot] = 1; m_key[slot] = k; m_age[slot] = 0;
  endtask

  task automatic model_release(input logic [7:0] b);
    int k;
    k = lookup(b);
    if (k < 0 || !m_held[k]) return;
    m_held[k] = 0;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && m_key[v] == k) begin m_act[v] = 0; m_age[v] = 0; end
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_drop = 0;
    if (m_after_e0f0)      m_after_e0f0 = 0;
    else if (m_after_e0) begin m_after_e0 = 0; m_after_e0f0 = (b == 8'hF0); end
    else if (m_after_f0) begin m_after_f0 = 0; model_release(b); end
    else if (b == 8'hF0)   m_after_f0 = 1;
    else if (b == 8'hE0)   m_after_e0 = 1;
    else                   model_press(b);
  endtask

  function automatic exp_t snap();
    exp_t e;
    e = '0;
    for (int v = 0; v < NV; v++) begin
      e.act[v] = m_act[v];
      e.vkey[v*KW +: KW] = KW'(m_key[v]);
    end
    for (int k = 0; k < NK; k++) e.held[k] = m_held[k];
    e.oct  = 2'(m_oct);
    e.drop = m_drop;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_all(input exp_t e, input string tag);
    chk({tag, ".voice_active"}, 32'(voice_active), 32'(e.act));
    chk({tag, ".voice_key"},    32'(voice_key),    32'(e.vkey));
    chk({tag, ".key_held"},     32'(key_held),     32'(e.held));
    chk({tag, ".octave"},       32'(octave),       32'(e.oct));
    chk({tag, ".drop_pulse"},   32'(drop_pulse),   32'(e.drop));
  endtask

  // Monitor: one registered response per accepted byte, otherwise no drop.
  logic kv_d;
  always @(posedge sys_clk or posedge rst)
    if (rst) kv_d <= 1'b0;
    else     kv_d <= key_valid;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (kv_d) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: got response with empty queue expected none at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          compare_all(mon_e, "byte");
        end
      end else begin
        chk("drop_idle", 32'(drop_pulse), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    key_code  = b;
    key_valid = 1'b1;
    model_byte(b);
    sb_q.push_back(snap());
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    key_valid = 1'b0;
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic release_all();
    for (int k = 0; k < NK; k++) begin send(8'hF0); send(keymap[k]); end
    idle(2);
  endtask

  logic [7:0] pool_b;

  initial begin
    model_reset();
    #12;
    compare_all(snap(), "reset");
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Reset right after a break prefix: next byte must be a make.
    send(8'hF0); idle(2);
    rst = 1'b1; model_reset(); #2;
    compare_all(snap(), "reset_mid");
    rst = 1'b0;
    @(posedge sys_clk); #1;
    send(8'h1C); idle(2);
    chk("mid_rst_act", 32'(voice_active), 32'h1);
    chk("mid_rst_key0", 32'(voice_key[2:0]), 32'd0);
    release_all();

    send(8'h1C); send(8'h1B); idle(2);
    chk("two_act", 32'(voice_active), 32'h3);
    chk("two_key0", 32'(voice_key[2:0]), 32'd0);
    chk("two_key1", 32'(voice_key[5:3]), 32'd1);
    chk("two_held", 32'(key_held), 32'h03);
    send(8'hF0); send(8'h1C); idle(2);
    chk("brk_act", 32'(voice_active), 32'h2);
    chk("brk_held", 32'(key_held), 32'h02);
    release_all();

    send(8'h1C); send(8'h1C); send(8'h1C); idle(2);
    chk("typematic_act", 32'(voice_active), 32'h1);
    release_all();

    repeat (4) send(8'h22);
    idle(1);
    chk("oct_up_sat", 32'(octave), 32'd3);
    repeat (5) send(8'h1A);
    idle(1);
    chk("oct_dn_sat", 32'(octave), 32'd0);
    send(8'hF0); send(8'h22); idle(1);
    chk("oct_brk_ign", 32'(octave), 32'd0);

    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h1B); idle(2);
    chk("ext_act", 32'(voice_active), 32'h0);
    chk("ext_held", 32'(key_held), 32'h0);

    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34); idle(2);
    chk("full_act", 32'(voice_active), 32'hF);
    chk("full_held", 32'(key_held), 32'h1F);
`ifdef VOICE_STEAL_EN
    chk("steal_key0", 32'(voice_key[2:0]), 32'd4);
`else
    chk("drop_key0", 32'(voice_key[2:0]), 32'd0);
`endif
    release_all();

    // Randomized traffic, back-to-back and gapped.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 15))
        0, 1, 2, 3, 4, 5, 6, 7: pool_b = keymap[$urandom_range(0, NK - 1)];
        8, 9, 10:               pool_b = 8'hF0;
        11:                     pool_b = 8'hE0;
        12:                     pool_b = 8'h1A;
        13:                     pool_b = 8'h22;
        default:                pool_b = 8'($urandom_range(0, 255));
      endcase
      send(pool_b);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
